// File: rtl/multi_add_pkg.sv
// Shared elaboration helpers for the pipelined multi-operand adder.
package multi_add_pkg;

    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = unsigned'(i + 1);
        end
        return r;
    endfunction

    // Result width: one bit per tree level, plus one more if an all-max set with carry-in overflows.
    function automatic int unsigned sum_w(input int unsigned width, input int unsigned num_in);
        int unsigned     w     = width + clog2_f(num_in);
        longint unsigned bound = 64'(num_in) * ((64'd1 << width) - 64'd1) + 64'd1;
        if (bound >= (64'd1 << w)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/cla_add.sv
// Combinational W-bit carry-lookahead adder with Kogge-Stone prefix carries and carry-out.
module cla_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W:0]   sum
);

    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic [W:0]   c;

    always_comb begin
        gg = a & b;
        pp = a | b;
        // Descending i keeps the lower-index operands at their previous-round values.
        for (int d = 1; d < int'(W); d = d * 2) begin
            for (int i = int'(W) - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            c[i+1] = gg[i] | (pp[i] & cin);
        end
        sum = {c[W], (a ^ b) ^ c[W-1:0]};
    end

endmodule

// File: rtl/multi_operand_pipe_adder.sv
// Pipelined adder tree: NUM_IN operands plus carry-in, one register stage per tree level,
// valid/ready on both sides with a combinational ready chain.
module multi_operand_pipe_adder
    import multi_add_pkg::*;
#(
    parameter  int unsigned WIDTH  = 6,
    parameter  int unsigned NUM_IN = 4,
    parameter  int unsigned SIGNED = 0,
    localparam int unsigned LEVELS = clog2_f(NUM_IN),
    localparam int unsigned SUM_W  = sum_w(WIDTH, NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SUM_W-1:0]        out_sum
);

    localparam int unsigned LEAVES = 1 << LEVELS;

    if (WIDTH < 2 || NUM_IN < 2) begin : g_param_check
        $error("multi_operand_pipe_adder: WIDTH and NUM_IN must both be >= 2");
    end

    logic [SUM_W-1:0] leaf   [LEAVES];
    // Heap layout: node 1 is the root, children of node n are 2n and 2n+1.
    logic [SUM_W-1:0] node_q [1:LEAVES-1];
    logic [LEVELS:1]  valid_q;
    logic [LEVELS:1]  up_valid;
    logic             ready  [1:LEVELS+1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < NUM_IN) begin : g_op
            assign leaf[i] = {{(SUM_W - WIDTH){(SIGNED != 0) && in_data[i*WIDTH + WIDTH - 1]}},
                              in_data[i*WIDTH +: WIDTH]};
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    always_comb begin
        up_valid[1] = in_valid;
        for (int k = 2; k <= int'(LEVELS); k++) begin
            up_valid[k] = valid_q[k-1];
        end
    end

    always_comb begin
        ready[LEVELS+1] = out_ready;
        for (int k = int'(LEVELS); k >= 1; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int k = 1; k <= int'(LEVELS); k++) begin
                if (ready[k]) valid_q[k] <= up_valid[k];
            end
        end
    end

    for (genvar n = 1; n < LEAVES; n++) begin : g_node
        localparam int unsigned STG = LEVELS + 1 - clog2_f(n + 1);

        logic [SUM_W-1:0] a;
        logic [SUM_W-1:0] b;
        logic             cin;
        logic [SUM_W:0]   s;
        logic [SUM_W-1:0] q;
        logic             unused_cout;

        if (2 * n >= LEAVES) begin : g_from_leaf
            assign a = leaf[2*n - LEAVES];
            assign b = leaf[2*n + 1 - LEAVES];
        end else begin : g_from_node
            assign a = node_q[2*n];
            assign b = node_q[2*n + 1];
        end

        // Carry-in joins only at the level-1 adder of operands 0 and 1.
        assign cin = (n == LEAVES / 2) ? in_cin : 1'b0;

        cla_add #(.W(SUM_W)) u_add (
            .a   (a),
            .b   (b),
            .cin (cin),
            .sum (s)
        );

        assign unused_cout = s[SUM_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (ready[STG] && up_valid[STG]) begin
                q <= s[SUM_W-1:0];
            end
        end

        assign node_q[n] = q;
    end

    assign in_ready  = ready[1];
    assign out_valid = valid_q[LEVELS];
    assign out_sum   = node_q[1];

endmodule
